// File: rtl/dma_pkg.sv
// Constants and types shared by the DMA request arbiter and the DMA engine.
package dma_pkg;

  localparam logic READ  = 1'b0;  // shm -> proc
  localparam logic WRITE = 1'b1;  // proc -> shm

  localparam int SIZE      = 4;
  localparam int PROCSIZE  = 4;
  localparam int PAGE_SIZE = 16;
  localparam int WORD_SIZE = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } arb_state_t;

  typedef struct packed {
    logic                action;
    logic [SIZE-1:0]     ptr;
    logic [PROCSIZE-1:0] start;
    logic [PROCSIZE-1:0] length;
  } dma_req_t;

endpackage

// File: rtl/dma_request_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of pending_i searching
// upward from last_grant_i+1, wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] pending_i,
  input  logic [W-1:0] last_grant_i,
  output logic [W-1:0] grant_o,
  output logic         any_o
);

  int idx;

  // Scanning from the farthest offset down lets the nearest candidate win.
  always_comb begin
    grant_o = '0;
    any_o   = |pending_i;
    idx     = 0;
    for (int off = N; off >= 1; off--) begin
      idx = (int'(last_grant_i) + off) % N;
      if (pending_i[W'(idx)]) grant_o = W'(idx);
    end
  end

endmodule

// File: rtl/dma_request_arbiter.sv
// Captures toggle-style copy requests per processor, serves them round-robin
// to the DMA over valid/ready, and returns a toggle acknowledge on completion.
module dma_request_arbiter #(
  parameter int PROC_CNT = 4,
  parameter int SIZE     = dma_pkg::SIZE,
  parameter int PROCSIZE = dma_pkg::PROCSIZE,
  parameter int PW       = $clog2(PROC_CNT)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [PROC_CNT-1:0]          trigger,
  input  logic [PROC_CNT-1:0]          action,
  input  logic [PROC_CNT*SIZE-1:0]     ptr,
  input  logic [PROC_CNT*PROCSIZE-1:0] copy_start,
  input  logic [PROC_CNT*PROCSIZE-1:0] copy_length,
  output logic [PROC_CNT-1:0]          ack,
  output logic [PROC_CNT-1:0]          busy,
  output logic [PROC_CNT-1:0]          overrun,
  output logic                         req_valid,
  input  logic                         req_ready,
  output logic [PW-1:0]                req_proc,
  output logic                         req_action,
  output logic [SIZE-1:0]              req_ptr,
  output logic [PROCSIZE-1:0]          req_start,
  output logic [PROCSIZE-1:0]          req_length,
  input  logic                         dma_done
);

  import dma_pkg::*;

  arb_state_t state_q, state_d;

  logic [PROC_CNT-1:0] last_trig_q;
  logic [PROC_CNT-1:0] pending_q, pending_d;
  logic [PROC_CNT-1:0] overrun_q, overrun_d;
  logic [PROC_CNT-1:0] ack_q, ack_d;
  logic [PW-1:0]       last_grant_q, last_grant_d;

  logic                req_valid_q, req_valid_d;
  logic [PW-1:0]       req_proc_q, req_proc_d;
  logic                req_action_q, req_action_d;
  logic [SIZE-1:0]     req_ptr_q, req_ptr_d;
  logic [PROCSIZE-1:0] req_start_q, req_start_d;
  logic [PROCSIZE-1:0] req_length_q, req_length_d;

  logic                slot_action_q [PROC_CNT];
  logic [SIZE-1:0]     slot_ptr_q    [PROC_CNT];
  logic [PROCSIZE-1:0] slot_start_q  [PROC_CNT];
  logic [PROCSIZE-1:0] slot_length_q [PROC_CNT];

  logic [PROC_CNT-1:0] req_vec, clr_vec, accept_vec;
  logic [PW-1:0]       pick;
  logic                pick_any;

  rr_pick #(.N(PROC_CNT), .W(PW)) u_rr_pick (
    .pending_i    (pending_q),
    .last_grant_i (last_grant_q),
    .grant_o      (pick),
    .any_o        (pick_any)
  );

  // A slot freed by dma_done this cycle may be refilled in the same cycle.
  always_comb begin
    clr_vec = '0;
    if (state_q == WAIT_DONE && dma_done) clr_vec[req_proc_q] = 1'b1;
    req_vec    = trigger ^ last_trig_q;
    accept_vec = req_vec & (~pending_q | clr_vec);
    pending_d  = (pending_q & ~clr_vec) | accept_vec;
    overrun_d  = overrun_q | (req_vec & ~accept_vec);
  end

  always_comb begin
    state_d      = state_q;
    ack_d        = ack_q;
    last_grant_d = last_grant_q;
    req_valid_d  = req_valid_q;
    req_proc_d   = req_proc_q;
    req_action_d = req_action_q;
    req_ptr_d    = req_ptr_q;
    req_start_d  = req_start_q;
    req_length_d = req_length_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d      = ISSUE;
          req_valid_d  = 1'b1;
          req_proc_d   = pick;
          req_action_d = slot_action_q[pick];
          req_ptr_d    = slot_ptr_q[pick];
          req_start_d  = slot_start_q[pick];
          req_length_d = slot_length_q[pick];
        end
      end
      ISSUE: begin
        if (req_ready) begin
          state_d     = WAIT_DONE;
          req_valid_d = 1'b0;
        end
      end
      WAIT_DONE: begin
        if (dma_done) begin
          state_d             = IDLE;
          ack_d[req_proc_q]   = ~ack_q[req_proc_q];
          last_grant_d        = req_proc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_trig_q  <= '0;
      pending_q    <= '0;
      overrun_q    <= '0;
      ack_q        <= '0;
      last_grant_q <= PW'(PROC_CNT - 1);
      req_valid_q  <= 1'b0;
      req_proc_q   <= '0;
      req_action_q <= 1'b0;
      req_ptr_q    <= '0;
      req_start_q  <= '0;
      req_length_q <= '0;
      for (int i = 0; i < PROC_CNT; i++) begin
        slot_action_q[i] <= 1'b0;
        slot_ptr_q[i]    <= '0;
        slot_start_q[i]  <= '0;
        slot_length_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      last_trig_q  <= trigger;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      ack_q        <= ack_d;
      last_grant_q <= last_grant_d;
      req_valid_q  <= req_valid_d;
      req_proc_q   <= req_proc_d;
      req_action_q <= req_action_d;
      req_ptr_q    <= req_ptr_d;
      req_start_q  <= req_start_d;
      req_length_q <= req_length_d;
      for (int i = 0; i < PROC_CNT; i++) begin
        if (accept_vec[i]) begin
          slot_action_q[i] <= action[i];
          slot_ptr_q[i]    <= ptr[i*SIZE +: SIZE];
          slot_start_q[i]  <= copy_start[i*PROCSIZE +: PROCSIZE];
          slot_length_q[i] <= copy_length[i*PROCSIZE +: PROCSIZE];
        end
      end
    end
  end

  assign ack        = ack_q;
  assign busy       = pending_q;
  assign overrun    = overrun_q;
  assign req_valid  = req_valid_q;
  assign req_proc   = req_proc_q;
  assign req_action = req_action_q;
  assign req_ptr    = req_ptr_q;
  assign req_start  = req_start_q;
  assign req_length = req_length_q;

endmodule

// File: tb/tb_dma_request_arbiter.sv
// Directed bench for dma_request_arbiter: capture, round-robin order,
// overrun, stalled handshake, coincident done/request and mid-transfer reset.
module tb_dma_request_arbiter;

  localparam int PC = 4;
  localparam int SZ = 4;
  localparam int PS = 4;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [PC-1:0]  trigger, action;
  logic [PC*SZ-1:0] ptr;
  logic [PC*PS-1:0] copy_start, copy_length;
  logic [PC-1:0]  ack, busy, overrun;
  logic           req_valid, req_ready, req_action, dma_done;
  logic [1:0]     req_proc;
  logic [SZ-1:0]  req_ptr;
  logic [PS-1:0]  req_start, req_length;

  int total = 0;
  int passed = 0;
  logic [PC-1:0] exp_ack = '0;

  dma_request_arbiter #(.PROC_CNT(PC), .SIZE(SZ), .PROCSIZE(PS)) dut (
    .clock(clock), .reset_n(reset_n), .trigger(trigger), .action(action),
    .ptr(ptr), .copy_start(copy_start), .copy_length(copy_length),
    .ack(ack), .busy(busy), .overrun(overrun), .req_valid(req_valid),
    .req_ready(req_ready), .req_proc(req_proc), .req_action(req_action),
    .req_ptr(req_ptr), .req_start(req_start), .req_length(req_length),
    .dma_done(dma_done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic set_op(input int p, input logic a, input logic [3:0] pt,
                        input logic [3:0] st, input logic [3:0] ln);
    action[p]            = a;
    ptr[p*SZ +: SZ]      = pt;
    copy_start[p*PS +: PS]  = st;
    copy_length[p*PS +: PS] = ln;
  endtask

  // Wait for a grant, check it, accept it and complete it.
  task automatic serve(input int p, input logic [3:0] pt);
    for (int i = 0; i < 10 && !req_valid; i++) tick();
    total++;
    if (req_valid !== 1'b1 || req_proc !== 2'(p) || req_ptr !== pt)
      $display("FAIL serve_grant: valid=%b proc=%0d ptr=%0h expected proc=%0d ptr=%0h",
               req_valid, req_proc, req_ptr, p, pt);
    else passed++;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    total++;
    if (req_valid !== 1'b0) $display("FAIL serve_valid_drop: got %b expected 0", req_valid);
    else passed++;
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    exp_ack[p] = ~exp_ack[p];
    total++;
    if (ack !== exp_ack || busy[p] !== 1'b0)
      $display("FAIL serve_ack: ack=%b busy=%b expected ack=%b busy[%0d]=0", ack, busy, exp_ack, p);
    else passed++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; trigger = '0; action = '0; ptr = '0; copy_start = '0;
    copy_length = '0; req_ready = 1'b0; dma_done = 1'b0;
    tick(); tick();
    total++;
    if ({ack, busy, overrun, req_valid, req_proc, req_action, req_ptr, req_start, req_length} !== '0)
      $display("FAIL reset_outputs: ack=%b busy=%b ovr=%b valid=%b expected all zero",
               ack, busy, overrun, req_valid);
    else passed++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_op(2, 1'b1, 4'd5, 4'd3, 4'd4);
    trigger[2] = ~trigger[2];
    tick();
    check("single_busy", 32'(busy), 32'b0100);
    check("single_valid_early", 32'(req_valid), 0);
    tick();
    total++;
    if (req_valid !== 1'b1 || req_proc !== 2'd2 || req_action !== 1'b1 ||
        req_ptr !== 4'd5 || req_start !== 4'd3 || req_length !== 4'd4)
      $display("FAIL single_fields: v=%b p=%0d a=%b ptr=%0d st=%0d len=%0d expected 1 2 1 5 3 4",
               req_valid, req_proc, req_action, req_ptr, req_start, req_length);
    else passed++;
    serve(2, 4'd5);
  endtask

  task automatic test_round_robin();
    set_op(0, 1'b0, 4'd9, 4'd1, 4'd2);
    trigger[0] = ~trigger[0];
    tick();
    serve(0, 4'd9);
    set_op(0, 1'b0, 4'd10, 4'd0, 4'd1);
    set_op(1, 1'b0, 4'd11, 4'd0, 4'd1);
    set_op(3, 1'b1, 4'd12, 4'd0, 4'd1);
    trigger = trigger ^ 4'b1011;
    tick();
    check("rr_busy_all", 32'(busy), 32'b1011);
    serve(1, 4'd11);
    serve(3, 4'd12);
    serve(0, 4'd10);
  endtask

  task automatic test_overrun();
    set_op(1, 1'b0, 4'd6, 4'd2, 4'd0);
    trigger[1] = ~trigger[1];
    tick(); tick();
    check("ovr_len_zero", 32'(req_length), 0);
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    set_op(1, 1'b1, 4'd15, 4'd15, 4'd15);
    trigger[1] = ~trigger[1];
    tick();
    check("ovr_flag", 32'(overrun), 32'b0010);
    check("ovr_snapshot", 32'(req_ptr), 6);
    dma_done = 1'b1; tick(); dma_done = 1'b0;
    exp_ack[1] = ~exp_ack[1];
    check("ovr_ack", 32'(ack), 32'(exp_ack));
    tick(); tick(); tick();
    check("ovr_no_extra", 32'({req_valid, busy}), 0);
  endtask

  task automatic test_stall();
    set_op(3, 1'b0, 4'd7, 4'd8, 4'd9);
    trigger[3] = ~trigger[3];
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      dma_done = (i == 2);
      tick();
      total++;
      if (req_valid !== 1'b1 || req_proc !== 2'd3 || req_ptr !== 4'd7 ||
          req_start !== 4'd8 || req_length !== 4'd9)
        $display("FAIL stall_hold[%0d]: v=%b p=%0d ptr=%0d st=%0d len=%0d", i,
                 req_valid, req_proc, req_ptr, req_start, req_length);
      else passed++;
    end
    dma_done = 1'b0;
    check("stall_done_ignored", 32'({ack, busy}), 32'({exp_ack, 4'b1000}));
    serve(3, 4'd7);
  endtask

  task automatic test_coincident();
    set_op(0, 1'b0, 4'd1, 4'd1, 4'd1);
    trigger[0] = ~trigger[0];
    tick(); tick();
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    set_op(0, 1'b1, 4'd13, 4'd14, 4'd2);
    trigger[0] = ~trigger[0];
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    exp_ack[0] = ~exp_ack[0];
    check("coin_ack", 32'(ack), 32'(exp_ack));
    check("coin_busy", 32'(busy), 32'b0001);
    tick();
    check("coin_reissue", 32'({req_valid, req_action, req_ptr, req_start}), 32'({1'b1, 1'b1, 4'd13, 4'd14}));
    serve(0, 4'd13);
  endtask

  task automatic test_reset_mid();
    set_op(2, 1'b0, 4'd3, 4'd3, 4'd3);
    trigger[2] = ~trigger[2];
    tick(); tick();
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    trigger = '0;
    #1;
    total++;
    if ({ack, busy, overrun, req_valid, req_proc, req_ptr, req_start, req_length} !== '0)
      $display("FAIL reset_mid: ack=%b busy=%b ovr=%b valid=%b ptr=%0h expected all zero",
               ack, busy, overrun, req_valid, req_ptr);
    else passed++;
    exp_ack = '0;
    tick();
    reset_n = 1'b1;
    tick();
    set_op(0, 1'b0, 4'd4, 4'd0, 4'd1);
    set_op(3, 1'b0, 4'd8, 4'd0, 4'd1);
    trigger = 4'b1001;
    tick();
    serve(0, 4'd4);
    serve(3, 4'd8);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overrun();
    test_stall();
    test_coincident();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dma_request_arbiter.md
# dma_request_arbiter

- Front end of the shared-memory DMA.
- Watches the per-processor toggle-style copy triggers and snapshots each request's operands into a per-processor slot.
- Picks one pending slot at a time in round-robin order and presents it to the DMA engine over a valid/ready handshake.
- Returns a toggle acknowledge to the requesting processor when the DMA reports completion.

## Interface
Parameters:
- PROC_CNT, 4, number of processors (≥2)
- SIZE, 4, shared-memory address width (ptr)
- PROCSIZE, 4, processor-local address/length width

Ports:
- clock  in  1  single clock domain
- reset_n  in  1  asynchronous, active-low reset
- trigger  in  PROC_CNT  per-proc request toggle; a change of level is one request
- action  in  PROC_CNT  per-proc direction: 0 = READ (shm→proc), 1 = WRITE (proc→shm)
- ptr  in  PROC_CNT*SIZE  per-proc shm start address, proc i at [i*SIZE +: SIZE]
- copy_start  in  PROC_CNT*PROCSIZE  per-proc local start address
- copy_length  in  PROC_CNT*PROCSIZE  per-proc word count
- ack  out  PROC_CNT  per-proc completion toggle
- busy  out  PROC_CNT  slot i pending or in service
- overrun  out  PROC_CNT  sticky, set when a trigger arrives on an occupied slot
- req_valid  out  1  request presented to the DMA
- req_ready  in  1  DMA accepts the request
- req_proc  out  $clog2(PROC_CNT)  granted processor index
- req_action / req_ptr / req_start / req_length  out  1/SIZE/PROCSIZE/PROCSIZE  snapshot of the granted slot
- dma_done  in  1  one-cycle completion pulse from the DMA

## Operation
- Edge detect: last_trigger[i] registers trigger[i]. A request on i is trigger[i] != last_trigger[i].
- Capture:
  - Request on i with slot i empty: set pending[i] and snapshot action/ptr/copy_start/copy_length into slot i.
  - Request on i with slot i occupied (pending or in service): request is dropped, snapshot unchanged, overrun[i] set.
- FSM states IDLE, ISSUE, WAIT_DONE:
  - IDLE: if any pending, grant the first pending index searching from last_grant+1 modulo PROC_CNT; load req_* from that slot; go to ISSUE.
  - ISSUE: hold req_valid and req_* stable. On req_ready, go to WAIT_DONE.
  - WAIT_DONE: on dma_done, toggle ack[req_proc], clear pending[req_proc], set last_grant to req_proc, go to IDLE.
- dma_done outside WAIT_DONE is ignored.
- busy[i] = pending[i].
- Simultaneous events:
  - A new request on i in the same cycle slot i is cleared by dma_done is accepted: set wins over clear, new snapshot taken.
  - Requests on several processors in one cycle are all captured.
- copy_length = 0 is forwarded unchanged; the arbiter does not filter it.
- Reset (asserted at any time, including mid-handshake) forces:
  - state = IDLE, last_grant = PROC_CNT-1 (so proc 0 wins first)
  - req_valid = 0, req_* = 0
  - pending = 0, ack = 0, overrun = 0, last_trigger = 0
  - An in-flight DMA transfer is abandoned. The DMA is reset from the same reset_n.

## Timing
- Request toggle sampled at edge k → pending/busy high after k.
- Grant at edge k+1 → req_valid high after k+1. Minimum trigger-to-valid latency is 2 edges.
- Handshake completes at the first edge with req_valid && req_ready, earliest k+2. req_valid drops after that edge.
- dma_done at edge m → ack toggles and busy drops after m. The next grant is at m+1.
- Back-to-back requests are spaced by one idle cycle (the IDLE grant cycle).
- Inputs are synchronous to clock; no synchronizers inside.

## Structure
- Shared package dma_pkg:
  - READ/WRITE action constants
  - SIZE, PROCSIZE, PAGE_SIZE, WORD_SIZE constants (the DMA imports the same package)
  - arb_state_t enum {IDLE, ISSUE, WAIT_DONE}
  - request struct {action, ptr, start, length}
- One sub-module, rr_pick: combinational round-robin picker (pending vector and last_grant in, grant index and any-valid out). It is reused for future multi-DMA arbitration.

## Test plan
- Reset, then proc 2 toggles trigger with ptr=5, start=3, length=4, action=WRITE → req_valid 2 edges later with req_proc=2 and those fields. After req_ready and dma_done, ack[2] toggles and busy[2] drops.
- Procs 0, 1, 3 trigger in the same cycle with last_grant=0 → grant order 1, 3, 0, one request per completion.
- Proc 1 toggles again while in service → overrun[1]=1, no extra request; the original snapshot is still on req_*.
- req_ready held low for 5 cycles → req_* stable and req_valid held; a dma_done pulse during ISSUE is ignored.
- dma_done for proc 0 coincides with a new proc-0 toggle → ack[0] toggles, busy[0] stays 1, a fresh request is issued with the new operands.
- reset_n pulsed low during WAIT_DONE → all outputs 0 immediately, proc 0 wins the next arbitration.
